// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
// ADDER_ARB_RR_EN selects round-robin arbitration; fixed priority otherwise.
package adder_arb_pkg;

  localparam int ADD_W   = 64;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } arb_state_t;

  // Index of the set bit; the OR-accumulation is exact for one-hot inputs.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational one-hot grant over a request vector.
// ADDER_ARB_RR_EN: search starts at i_ptr; otherwise lowest index wins and i_ptr is ignored.
module rr_grant
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx
);

  logic [MAX_REQ-1:0] w_grant_ext;

`ifdef ADDER_ARB_RR_EN
  always_comb begin
    int             w_pos;
    logic [IDW-1:0] w_pos_idx;
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    o_grant   = '0;
    w_pos     = 0;
    w_pos_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= NREQ) w_pos = w_pos - NREQ;
      w_pos_idx = IDW'(w_pos);
      if (i_req[w_pos_idx] && (o_grant == '0)) o_grant[w_pos_idx] = 1'b1;
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (i_req[k] && (o_grant == '0)) o_grant[k] = 1'b1;
    end
  end
`endif

  assign w_grant_ext = MAX_REQ'(o_grant);
  assign o_idx       = IDW'(onehot_to_idx(w_grant_ext));

endmodule

// File: rtl/adder_share_arb.sv
// Arbitrates NREQ requesters onto one 64-bit prefix adder, one transaction in flight.
// ADDER_ARB_RR_EN enables the round-robin pointer; default build is fixed priority.
module adder_share_arb
  import adder_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH:0]        resp_sum,
  output logic [IDW-1:0]        resp_id,
  output logic                  busy
);

  localparam int LVLS = $clog2(WIDTH);

  if (WIDTH != ADD_W) begin : g_width_check
    $error("adder_share_arb: WIDTH must equal the adder core width");
  end
  if ((NREQ < 2) || (NREQ > MAX_REQ)) begin : g_nreq_check
    $error("adder_share_arb: NREQ must be in 2..8");
  end

  arb_state_t       r_state, w_state_nxt;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_grant_idx;
  logic [IDW-1:0]   w_ptr;
  logic             w_accept;
  logic [WIDTH-1:0] r_op_a, r_op_b;
  logic [IDW-1:0]   r_id_q;
  logic [WIDTH:0]   r_resp_sum;
  logic [IDW-1:0]   r_resp_id;
  logic [WIDTH:0]   w_core_sum;

  rr_grant #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_grant (
    .i_req   (req_valid),
    .i_ptr   (w_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx)
  );

`ifdef ADDER_ARB_RR_EN
  logic [IDW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
    end
  end
  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = w_grant;
        if (|req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC:    w_state_nxt = RESP;
      RESP:    if (resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Kogge-Stone prefix adder with carry-in tied low.
  always_comb begin : prefix_core
    logic [WIDTH-1:0] w_p0, w_g, w_p, w_g_prev, w_p_prev, w_carry;
    w_p0 = r_op_a ^ r_op_b;
    w_g  = r_op_a & r_op_b;
    w_p  = w_p0;
    w_g_prev = '0;
    w_p_prev = '0;
    for (int l = 0; l < LVLS; l++) begin
      w_g_prev = w_g;
      w_p_prev = w_p;
      for (int i = (1 << l); i < WIDTH; i++) begin
        w_g[i] = w_g_prev[i] | (w_p_prev[i] & w_g_prev[i-(1<<l)]);
        w_p[i] = w_p_prev[i] & w_p_prev[i-(1<<l)];
      end
    end
    w_carry    = {w_g[WIDTH-2:0], 1'b0};
    w_core_sum = {w_g[WIDTH-1], w_p0 ^ w_carry};
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand and result registers are reset too, so outputs read zero after reset rather than stale data.
      r_state    <= IDLE;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_id_q     <= '0;
      r_resp_sum <= '0;
      r_resp_id  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op_a <= req_a[w_grant_idx*WIDTH +: WIDTH];
        r_op_b <= req_b[w_grant_idx*WIDTH +: WIDTH];
        r_id_q <= w_grant_idx;
      end
      if (r_state == CALC) begin
        r_resp_sum <= w_core_sum;
        r_resp_id  <= r_id_q;
      end
    end
  end

  assign resp_valid = (r_state == RESP);
  assign resp_sum   = r_resp_sum;
  assign resp_id    = r_resp_id;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb: spec-level model, response scoreboard, directed and random stimulus.
module tb_adder_share_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 64;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  resp_valid, resp_ready;
  logic [WIDTH:0]        resp_sum;
  logic [IDW-1:0]        resp_id;
  logic                  busy;

  always #5 clk = ~clk;

  adder_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] op_of(input logic [NREQ*WIDTH-1:0] v, input int k);
    return v[k*WIDTH +: WIDTH];
  endfunction

  // Arbitration rule: first valid requester searching upward from the priority start, wrapping.
  function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
    int start;
`ifdef ADDER_ARB_RR_EN
    start = ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  // Spec-level model: phase 0 idle, 1 computing, 2 result offered.
  typedef struct {
    logic [64:0] sum;
    int          id;
  } exp_t;

  bit          armed = 1'b0;
  int          m_ph  = 0;
  int          m_ptr = 0;
  logic [64:0] m_pend_sum, m_out_sum;
  int          m_pend_id, m_out_id;
  exp_t        sb[$];
  int          n_acc = 0, n_resp = 0, n_drop = 0;
  int          acc_idx[$], acc_cyc[$];

  always @(negedge clk) begin
    int   g;
    exp_t e;
    g = model_grant(req_valid, m_ptr);
    if (armed) begin
      check("req_ready", req_ready, (m_ph == 0 && g >= 0) ? (65'd1 << g) : 65'd0);
      check("resp_valid", resp_valid, (m_ph == 2));
      check("busy", busy, (m_ph != 0));
      check("resp_sum", resp_sum, m_out_sum);
      check("resp_id", resp_id, m_out_id);
      if (!rst) begin
        for (int k = 0; k < NREQ; k++) begin
          if (req_valid[k] && req_ready[k]) begin
            e.sum = {1'b0, op_of(req_a, k)} + {1'b0, op_of(req_b, k)};
            e.id  = k;
            sb.push_back(e);
            acc_idx.push_back(k);
            acc_cyc.push_back(cyc);
            n_acc++;
          end
        end
        if (resp_valid && resp_ready) begin
          if (sb.size() == 0) begin
            check("sb_unsolicited", 1, 0);
          end else begin
            e = sb.pop_front();
            check("sb_sum", resp_sum, e.sum);
            check("sb_id", resp_id, e.id);
            n_resp++;
          end
        end
      end
    end
    if (rst) begin
      armed     = 1'b1;
      m_ph      = 0;
      m_ptr     = 0;
      m_out_sum = '0;
      m_out_id  = 0;
      n_drop   += sb.size();
      sb.delete();
    end else if (armed) begin
      case (m_ph)
        0: if (g >= 0) begin
          m_pend_sum = {1'b0, op_of(req_a, g)} + {1'b0, op_of(req_b, g)};
          m_pend_id  = g;
          m_ptr      = (g + 1) % NREQ;
          m_ph       = 1;
        end
        1: begin
          m_out_sum = m_pend_sum;
          m_out_id  = m_pend_id;
          m_ph      = 2;
        end
        default: if (resp_ready) m_ph = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [63:0] a, input logic [63:0] b);
    req_a[k*WIDTH +: WIDTH] = a;
    req_b[k*WIDTH +: WIDTH] = b;
  endtask

  initial begin
    int exp_order[5];
    int start_resp, budget;
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_sum", resp_sum, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_req_ready", req_ready, 0);
    rst = 1'b0;

    // Single request from requester 2, carry out of the top bit.
    set_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    req_valid = 4'b0100;
    #1;
    check("t1_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check("t1_busy_calc", busy, 1);
    check("t1_no_valid_calc", resp_valid, 0);
    tick();
    check("t1_valid", resp_valid, 1);
    check("t1_sum", resp_sum, 65'h1_0000_0000_0000_0000);
    check("t1_id", resp_id, 2);
    check("t1_busy_resp", busy, 1);
    tick();
    check("t1_done_valid", resp_valid, 0);
    check("t1_done_busy", busy, 0);

    // Operands change right after the accept; only the accepted values count.
    set_op(1, 64'd5, 64'd7);
    req_valid = 4'b0010;
    tick();
    set_op(1, 64'd100, 64'd100);
    tick();
    req_valid = '0;
    check("t2_sum", resp_sum, 65'd12);
    check("t2_id", resp_id, 1);
    tick();

    // Backpressure: result held while other requesters keep asking.
    resp_ready = 1'b0;
    set_op(3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001);
    req_valid = 4'b1000;
    tick();
    req_valid = 4'hF;
    tick();
    check("bp_valid_start", resp_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", resp_valid, 1);
      check("bp_sum", resp_sum, 65'h1_0000_0000_0000_0001);
      check("bp_id", resp_id, 3);
      check("bp_no_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    tick();
    check("bp_release_busy", busy, 0);
    check("bp_release_valid", resp_valid, 0);
    req_valid = '0;

    // Reset while the operation is in CALC: it is dropped.
    set_op(0, 64'd3, 64'd4);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_busy", busy, 0);
    check("mr_valid", resp_valid, 0);
    check("mr_sum", resp_sum, 0);
    check("mr_id", resp_id, 0);
    check("mr_ready", req_ready, 0);
    repeat (4) begin
      tick();
      check("mr_no_resp", resp_valid, 0);
    end

    // All requesters valid continuously: grant order and accept spacing.
`ifdef ADDER_ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    acc_idx.delete();
    acc_cyc.delete();
    for (int k = 0; k < NREQ; k++) set_op(k, 64'(k + 1) * 64'h1111, 64'(k + 10));
    req_valid = 4'hF;
    repeat (14) tick();
    req_valid = '0;
    repeat (3) tick();
    check("order_count", acc_idx.size(), 5);
    for (int i = 0; i < 5 && i < acc_idx.size(); i++) check("order_idx", acc_idx[i], exp_order[i]);
    for (int i = 0; i < 4 && i + 1 < acc_cyc.size(); i++) check("order_gap", acc_cyc[i+1] - acc_cyc[i], 3);

    // Random regression.
    start_resp = n_resp;
    budget     = 0;
    while ((n_resp - start_resp < 10000) && (budget < 80000)) begin
      req_valid = 4'($urandom);
      for (int k = 0; k < NREQ; k++) begin
        if ($urandom_range(0, 7) == 0) set_op(k, '1, {$urandom, $urandom});
        else set_op(k, {$urandom, $urandom}, {$urandom, $urandom});
      end
      resp_ready = 1'($urandom);
      tick();
      budget++;
    end
    check("rand_responses", n_resp - start_resp, 10000);

    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (5) tick();
    check("drain_empty", sb.size(), 0);
    check("drain_idle", busy, 0);
    check("answered_once", n_resp + n_drop, n_acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
